// File: rtl/cmp_arbiter.sv
// Two-requester arbiter in front of one shared 4-bit unsigned comparator.
// Fixed three-cycle transaction: grant pulse, then done pulse with eq/gt/sm.
module comparator_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       eq,
    output logic       gt,
    output logic       sm
);
    assign eq = (a == b);
    assign gt = (a > b);
    assign sm = (a < b);
endmodule

module cmp_arbiter #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic       req1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       eq,
    output logic       gt,
    output logic       sm,
    output logic       busy
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CMP  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t     state_r;
    state_t     state_next_s;
    logic       any_req_s;
    logic       win_s;
    logic       owner_r;
    logic       last_r;
    logic [3:0] op_a_r;
    logic [3:0] op_b_r;
    logic       cmp_eq_s;
    logic       cmp_gt_s;
    logic       cmp_sm_s;
    logic       gnt0_r;
    logic       gnt1_r;
    logic       done0_r;
    logic       done1_r;
    logic       eq_r;
    logic       gt_r;
    logic       sm_r;
    logic       busy_r;

    assign any_req_s = req0 | req1;

    comparator_4bit u_cmp (
        .a  (op_a_r),
        .b  (op_b_r),
        .eq (cmp_eq_s),
        .gt (cmp_gt_s),
        .sm (cmp_sm_s)
    );

    // Winner selection; last_r names the requester granted most recently
    always_comb begin
        win_s = 1'b0;
        if (req0 && req1) begin
            if (PRIO_FIXED) begin
                win_s = 1'b0;
            end else begin
                win_s = ~last_r;
            end
        end else if (req1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_next_s = ST_CMP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CMP:  state_next_s = ST_RESP;
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, grant/done pulses and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_r  <= 4'd0;
            op_b_r  <= 4'd0;
            owner_r <= 1'b0;
            last_r  <= 1'b1;
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
            done0_r <= 1'b0;
            done1_r <= 1'b0;
            eq_r    <= 1'b0;
            gt_r    <= 1'b0;
            sm_r    <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
            done0_r <= 1'b0;
            done1_r <= 1'b0;
            busy_r  <= (state_next_s != ST_IDLE);
            if ((state_r == ST_IDLE) && any_req_s) begin
                op_a_r  <= win_s ? a1 : a0;
                op_b_r  <= win_s ? b1 : b0;
                owner_r <= win_s;
                last_r  <= win_s;
                gnt0_r  <= ~win_s;
                gnt1_r  <= win_s;
            end else if (state_r == ST_CMP) begin
                eq_r    <= cmp_eq_s;
                gt_r    <= cmp_gt_s;
                sm_r    <= cmp_sm_s;
                done0_r <= ~owner_r;
                done1_r <= owner_r;
            end else begin
                op_a_r  <= op_a_r;
                op_b_r  <= op_b_r;
            end
        end
    end

    assign gnt0  = gnt0_r;
    assign gnt1  = gnt1_r;
    assign done0 = done0_r;
    assign done1 = done1_r;
    assign eq    = eq_r;
    assign gt    = gt_r;
    assign sm    = sm_r;
    assign busy  = busy_r;
endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter share one stimulus
// stream; a transaction-level model predicts grants and results for each.
module tb_cmp_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0;
    logic       req1;
    logic [3:0] a0;
    logic [3:0] b0;
    logic [3:0] a1;
    logic [3:0] b1;
    logic [1:0] g0;
    logic [1:0] g1;
    logic [1:0] d0;
    logic [1:0] d1;
    logic [1:0] eqv;
    logic [1:0] gtv;
    logic [1:0] smv;
    logic [1:0] bsy;

    always #5 clk = ~clk;

    cmp_arbiter #(.PRIO_FIXED(1'b0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(g0[0]), .gnt1(g1[0]), .done0(d0[0]), .done1(d1[0]),
        .eq(eqv[0]), .gt(gtv[0]), .sm(smv[0]), .busy(bsy[0])
    );

    cmp_arbiter #(.PRIO_FIXED(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(g0[1]), .gnt1(g1[1]), .done0(d0[1]), .done1(d1[1]),
        .eq(eqv[1]), .gt(gtv[1]), .sm(smv[1]), .busy(bsy[1])
    );

    typedef struct {
        int   gcyc;
        logic win;
        logic eq;
        logic gt;
        logic sm;
    } exp_t;

    exp_t       sb [2][$];
    int         gap [2];
    logic       last [2];
    logic [2:0] res [2];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input int lane, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d cycle %0d: got %0h expected %0h", name, lane, cyc, act, exp);
        end
    endtask

    // Reference model: one transaction per lane, a new one accepted two edges after the last
    initial begin
        logic       w;
        logic [3:0] x;
        logic [3:0] y;
        exp_t       e;
        for (int l = 0; l < 2; l++) begin
            gap[l]  = 0;
            last[l] = 1'b1;
        end
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            for (int l = 0; l < 2; l++) begin
                if (!rst_n) begin
                    gap[l]  = 0;
                    last[l] = 1'b1;
                    sb[l].delete();
                end else if (gap[l] > 0) begin
                    gap[l] = gap[l] - 1;
                end else if (req0 || req1) begin
                    if (req0 && req1) w = (l == 1) ? 1'b0 : ~last[l];
                    else w = req1;
                    x = w ? a1 : a0;
                    y = w ? b1 : b0;
                    e.gcyc = cyc;
                    e.win  = w;
                    e.eq   = (int'(x) == int'(y));
                    e.gt   = (int'(x) > int'(y));
                    e.sm   = (int'(x) < int'(y));
                    sb[l].push_back(e);
                    last[l] = w;
                    gap[l]  = 2;
                end
            end
        end
    end

    // Monitor: compares DUT outputs on the falling edge against the scoreboard
    initial begin
        logic eg;
        logic ed;
        logic w;
        for (int l = 0; l < 2; l++) res[l] = 3'b000;
        forever begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                if (!rst_n) begin
                    check("reset_outputs", l,
                          {g0[l], g1[l], d0[l], d1[l], eqv[l], gtv[l], smv[l], bsy[l]}, 8'h00);
                    res[l] = 3'b000;
                end else begin
                    eg = 1'b0;
                    ed = 1'b0;
                    w  = 1'b0;
                    if (sb[l].size() > 0) begin
                        w  = sb[l][0].win;
                        eg = (sb[l][0].gcyc == cyc);
                        ed = (sb[l][0].gcyc + 1 == cyc);
                    end
                    check("gnt0", l, {7'd0, g0[l]}, {7'd0, eg & ~w});
                    check("gnt1", l, {7'd0, g1[l]}, {7'd0, eg & w});
                    check("done0", l, {7'd0, d0[l]}, {7'd0, ed & ~w});
                    check("done1", l, {7'd0, d1[l]}, {7'd0, ed & w});
                    if (ed) begin
                        res[l] = {sb[l][0].eq, sb[l][0].gt, sb[l][0].sm};
                        void'(sb[l].pop_front());
                    end
                    check("eq_gt_sm", l, {5'd0, eqv[l], gtv[l], smv[l]}, {5'd0, res[l]});
                    check("busy", l, {7'd0, bsy[l]}, {7'd0, (gap[l] != 0)});
                end
            end
        end
    end

    task automatic pulse(input logic r0, input logic r1,
                         input logic [3:0] x0, input logic [3:0] y0,
                         input logic [3:0] x1, input logic [3:0] y1);
        req0 = r0; req1 = r1;
        a0 = x0; b0 = y0; a1 = x1; b1 = y1;
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stimulus
    initial begin
        logic [31:0] r;
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
        idle(3);
        rst_n = 1'b1;
        idle(2);
        // single request, greater-than
        pulse(1'b1, 1'b0, 4'b0011, 4'b0001, 4'd0, 4'd0);
        idle(3);
        // requester 1: equal, then less-than
        pulse(1'b0, 1'b1, 4'd0, 4'd0, 4'b1001, 4'b1001);
        idle(3);
        pulse(1'b0, 1'b1, 4'd0, 4'd0, 4'b0011, 4'b1010);
        idle(3);
        // sustained tie
        req0 = 1'b1; req1 = 1'b1;
        a0 = 4'b1111; b0 = 4'b0000; a1 = 4'b0000; b1 = 4'b1111;
        idle(12);
        req0 = 1'b0; req1 = 1'b0;
        idle(3);
        // operand changes during the grant cycle must not leak in
        pulse(1'b1, 1'b0, 4'b1010, 4'b0011, 4'd0, 4'd0);
        a0 = 4'b0000;
        idle(3);
        // reset during CMP aborts the transaction
        req0 = 1'b1; a0 = 4'd5; b0 = 4'd2;
        @(negedge clk);
        req0 = 1'b0;
        #2 rst_n = 1'b0;
        idle(2);
        #2 rst_n = 1'b1;
        @(negedge clk);
        pulse(1'b1, 1'b0, 4'd7, 4'd7, 4'd0, 4'd0);
        idle(3);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            req0 = r[0] | r[2];
            req1 = r[1] | r[3];
            a0 = r[11:8];  b0 = r[15:12];
            a1 = r[19:16]; b1 = r[23:20];
            @(negedge clk);
        end
        req0 = 1'b0; req1 = 1'b0;
        idle(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
